// File: rtl/halt_controller_pkg.sv
// ---------------------------------------------------------------------------
// halt_controller_pkg
// Shared types and constants for the ebreak halt controller.
//   hc_state_t  : controller state encoding (RUN, DRAIN, HALTED, STEP)
//   DRAIN_CNT_W : width of the inline drain counter (DRAIN_CYCLES <= 15)
//   drain_load  : value loaded into the drain counter when a halt is accepted
// ---------------------------------------------------------------------------
package halt_controller_pkg;

    typedef enum logic [1:0] {
        HC_RUN    = 2'd0,
        HC_DRAIN  = 2'd1,
        HC_HALTED = 2'd2,
        HC_STEP   = 2'd3
    } hc_state_t;

    localparam int DRAIN_CNT_W = 4;

    // The counter counts down to zero, so a drain of N cycles loads N-1.
    function automatic logic [DRAIN_CNT_W-1:0] drain_load(input int cycles);
        return DRAIN_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/halt_controller.sv
// ---------------------------------------------------------------------------
// halt_controller
// Freezes fetch on an accepted ebreak, drains EX/MEM/WB, parks the core in
// HALTED until a resume pulse, then steps one cycle past the ebreak.
//
// Parameters
//   DRAIN_CYCLES : cycles for older instructions to leave EX/MEM/WB (1..15)
//   CNT_W        : width of the halt-event counter
// Ports
//   clk            in   core clock
//   rst_n          in   asynchronous active-low reset
//   halt_req       in   ebreak decoded in ID
//   id_valid       in   IF/ID holds a real instruction
//   flush          in   branch/jump flush of IF/ID this cycle
//   resume         in   single-cycle resume pulse
//   pc_write_en    out  PC load enable
//   if_id_write_en out  IF/ID load enable
//   id_ex_bubble   out  force NOP into ID/EX
//   draining       out  controller is in DRAIN
//   halted         out  controller is in HALTED
//   halt_count     out  completed entries into HALTED (saturating)
// ---------------------------------------------------------------------------
module halt_controller
    import halt_controller_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             halt_req,
    input  logic             id_valid,
    input  logic             flush,
    input  logic             resume,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             id_ex_bubble,
    output logic             draining,
    output logic             halted,
    output logic [CNT_W-1:0] halt_count
);

    hc_state_t              state_reg, state_next;
    logic [DRAIN_CNT_W-1:0] drain_cnt_reg, drain_cnt_next;
    logic [CNT_W-1:0]       halt_count_reg, halt_count_next;
    logic                   halt_accept;

    // A flushed ebreak is squashed and a bubble cannot be an ebreak.
    assign halt_accept = halt_req & id_valid & ~flush;

    // Next-state and output decode. RUN outputs are Mealy so the freeze takes
    // effect in the same cycle the ebreak sits in ID.
    always_comb begin
        state_next      = state_reg;
        drain_cnt_next  = drain_cnt_reg;
        halt_count_next = halt_count_reg;
        pc_write_en     = 1'b1;
        if_id_write_en  = 1'b1;
        id_ex_bubble    = 1'b0;
        draining        = 1'b0;
        halted          = 1'b0;

        case (state_reg)
            HC_RUN: begin
                if (halt_accept) begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_bubble   = 1'b1;
                    state_next     = HC_DRAIN;
                    drain_cnt_next = drain_load(DRAIN_CYCLES);
                end
            end
            HC_DRAIN: begin
                // resume is deliberately not looked at here
                pc_write_en    = 1'b0;
                if_id_write_en = 1'b0;
                id_ex_bubble   = 1'b1;
                draining       = 1'b1;
                if (drain_cnt_reg == '0) begin
                    state_next = HC_HALTED;
                    // count on the entry edge so halt_count and halted rise together
                    if (halt_count_reg != {CNT_W{1'b1}})
                        halt_count_next = halt_count_reg + 1'b1;
                end else begin
                    drain_cnt_next = drain_cnt_reg - 1'b1;
                end
            end
            HC_HALTED: begin
                pc_write_en    = 1'b0;
                if_id_write_en = 1'b0;
                id_ex_bubble   = 1'b1;
                halted         = 1'b1;
                if (resume)
                    state_next = HC_STEP;
            end
            HC_STEP: begin
                // Load the instruction after the ebreak while the ebreak
                // itself is replaced by a bubble; halt_req is ignored so the
                // same ebreak cannot re-trigger.
                id_ex_bubble = 1'b1;
                state_next   = HC_RUN;
            end
            default: begin
                state_next = HC_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= HC_RUN;
            drain_cnt_reg  <= '0;
            halt_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            drain_cnt_reg  <= drain_cnt_next;
            halt_count_reg <= halt_count_next;
        end
    end

    assign halt_count = halt_count_reg;

endmodule

// File: tb/tb_halt_controller.sv
// ---------------------------------------------------------------------------
// tb_halt_controller
// Random stimulus against a timeline model of the halt sequence. Two DUT
// instances share stimulus: one with a 16-bit counter and one with a 2-bit
// counter so saturation is exercised. The driver pushes the expected outputs
// of every cycle into a queue; the monitor pops and compares at the falling
// edge.
// ---------------------------------------------------------------------------
module tb_halt_controller;

    localparam int D      = 3;
    localparam int NCYC   = 4000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt_req, id_valid, flush, resume;
    logic        pc_a, ifid_a, bub_a, dr_a, ha_a;
    logic [15:0] cnt_a;
    logic        pc_b, ifid_b, bub_b, dr_b, ha_b;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    halt_controller #(.DRAIN_CYCLES(D), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .halt_req(halt_req), .id_valid(id_valid),
        .flush(flush), .resume(resume), .pc_write_en(pc_a),
        .if_id_write_en(ifid_a), .id_ex_bubble(bub_a), .draining(dr_a),
        .halted(ha_a), .halt_count(cnt_a)
    );

    halt_controller #(.DRAIN_CYCLES(D), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .halt_req(halt_req), .id_valid(id_valid),
        .flush(flush), .resume(resume), .pc_write_en(pc_b),
        .if_id_write_en(ifid_b), .id_ex_bubble(bub_b), .draining(dr_b),
        .halted(ha_b), .halt_count(cnt_b)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic        pc;
        logic        ifid;
        logic        bub;
        logic        dr;
        logic        ha;
        logic [15:0] cnt16;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   hcount_max = 0;

    // Timeline model: halt_t = cycle the ebreak was accepted (-1 = none),
    // resume_t = cycle resume was seen while halted (-1 = none).
    int halt_t, resume_t, hcount;

    task automatic push_exp(input int c, input bit pc, input bit ifid,
                            input bit bub, input bit dr, input bit ha);
        exp_t e;
        e.cyc   = 32'(c);
        e.pc    = pc;
        e.ifid  = ifid;
        e.bub   = bub;
        e.dr    = dr;
        e.ha    = ha;
        e.cnt16 = (hcount > 65535) ? 16'hffff : 16'(hcount);
        e.cnt2  = (hcount > 3) ? 2'd3 : 2'(hcount);
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        halt_t   = -1;
        resume_t = -1;
        hcount   = 0;
    endtask

    // Expected outputs for cycle c given the inputs already applied.
    task automatic model_cycle(input int c);
        if (halt_t < 0) begin
            if (halt_req && id_valid && !flush) begin
                halt_t = c;
                push_exp(c, 0, 0, 1, 0, 0);
            end else begin
                push_exp(c, 1, 1, 0, 0, 0);
            end
        end else if (c <= halt_t + D) begin
            push_exp(c, 0, 0, 1, 1, 0);
        end else if (resume_t < 0) begin
            if (c == halt_t + D + 1) begin
                hcount++;
                if (hcount > hcount_max) hcount_max = hcount;
            end
            push_exp(c, 0, 0, 1, 0, 1);
            if (resume) resume_t = c;
        end else begin
            push_exp(c, 1, 1, 1, 0, 0);
            halt_t   = -1;
            resume_t = -1;
        end
    endtask

    // Driver
    initial begin
        bit did_mid_reset;
        bit hold_resume;
        did_mid_reset = 0;
        hold_resume   = 0;
        rst_n = 1'b0; halt_req = 1'b0; id_valid = 1'b0; flush = 1'b0; resume = 1'b0;
        model_reset();
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            if (c < 3) begin
                push_exp(c, 1, 1, 0, 0, 0);
                continue;
            end
            if (rst_n == 1'b0) begin
                rst_n = 1'b1;
            end else if ((!did_mid_reset && halt_t >= 0 && c == halt_t + 2) ||
                         ($urandom_range(0, 699) == 0)) begin
                // asynchronous reset applied mid-cycle; outputs must follow at once
                did_mid_reset = 1;
                rst_n = 1'b0; halt_req = 1'b0; id_valid = 1'b0; flush = 1'b0; resume = 1'b0;
                model_reset();
                push_exp(c, 1, 1, 0, 0, 0);
                continue;
            end
            halt_req = ($urandom_range(0, 3) == 0);
            id_valid = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 49) == 0) hold_resume = ~hold_resume;
            resume   = hold_resume | ($urandom_range(0, 2) == 0);
            model_cycle(c);
        end
        @(posedge clk);
        #1;
        halt_req = 1'b0; resume = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
        end
        checks++;
        if (hcount_max < 4) begin
            errors++;
            $display("FAIL sat_coverage: max halt count %0d, required >= 4", hcount_max);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            exp_t a;
            e = exp_q.pop_front();
            a = e;
            a.pc = pc_a; a.ifid = ifid_a; a.bub = bub_a; a.dr = dr_a; a.ha = ha_a;
            a.cnt16 = cnt_a; a.cnt2 = cnt_b;
            checks++;
            if (a !== e || pc_b !== e.pc || ifid_b !== e.ifid || bub_b !== e.bub ||
                dr_b !== e.dr || ha_b !== e.ha) begin
                errors++;
                $display("FAIL outputs cyc=%0d: got pc=%b ifid=%b bub=%b dr=%b ha=%b cnt=%0d sat(pc=%b ifid=%b bub=%b dr=%b ha=%b cnt=%0d) required pc=%b ifid=%b bub=%b dr=%b ha=%b cnt=%0d sat_cnt=%0d",
                         e.cyc, pc_a, ifid_a, bub_a, dr_a, ha_a, cnt_a,
                         pc_b, ifid_b, bub_b, dr_b, ha_b, cnt_b,
                         e.pc, e.ifid, e.bub, e.dr, e.ha, e.cnt16, e.cnt2);
            end
        end
    end

endmodule
